// File: rtl/seq_muldiv_unit.sv
// Sequential unsigned 16-bit MUL/DIV/REM feeding the register-file write port; MULDIV_DIV_EN enables the divider.
// Latency: FIN (done/wr) 16 edges after the start edge; divide-by-zero and disabled-divider ops after 1 edge.
// Backpressure: none; start is accepted only while idle, and requests made while busy are dropped.
`timescale 1ns/1ps
module seq_muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       dst,
   output logic             busy,
   output logic             done,
   output logic             divz,
   output logic [WIDTH-1:0] d,
   output logic [2:0]       da,
   output logic             wr
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [1:0]         op_q;
   logic [2:0]         dst_q;
   logic               skip_q;
   logic [2*WIDTH-1:0] a_sh;   // MUL: shifted multiplicand; DIV: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   d_hold;
   logic [2:0]         da_hold;
   logic [WIDTH-1:0]   result;
   logic               skip_run, wr_en, last_iter;

   assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef MULDIV_DIV_EN
   logic               divz_q;
   logic [WIDTH:0]     partial, diff;
   logic [2*WIDTH-1:0] div_nxt;

   always_comb begin
      partial = {a_sh[2*WIDTH-1:WIDTH], a_sh[WIDTH-1]};
      diff    = partial - {1'b0, b_sh};
      if (!diff[WIDTH]) div_nxt = {diff[WIDTH-1:0], a_sh[WIDTH-2:0], 1'b1};
      else              div_nxt = {partial[WIDTH-1:0], a_sh[WIDTH-2:0], 1'b0};
   end

   assign skip_run = op[1] && (b == '0);
   assign wr_en    = 1'b1;
`else
   assign skip_run = op[1];
   assign wr_en    = !op_q[1];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Skipped ops still spend one RUN cycle so FIN always lands one edge after the request edge.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (skip_q || last_iter) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         op_q    <= '0;
         dst_q   <= '0;
         skip_q  <= 1'b0;
         a_sh    <= '0;
         prod    <= '0;
         b_sh    <= '0;
         d_hold  <= '0;
         da_hold <= '0;
`ifdef MULDIV_DIV_EN
         divz_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               op_q   <= op;
               dst_q  <= dst;
               skip_q <= skip_run;
               cnt    <= '0;
               a_sh   <= {{WIDTH{1'b0}}, a};
               b_sh   <= b;
               prod   <= '0;
`ifdef MULDIV_DIV_EN
               divz_q <= op[1] && (b == '0);
`endif
            end
            RUN: if (!skip_q) begin
               cnt <= last_iter ? '0 : cnt + 1'b1;
               if (!op_q[1]) begin
                  if (b_sh[0]) prod <= prod + a_sh;
                  a_sh <= a_sh << 1;
                  b_sh <= b_sh >> 1;
               end
`ifdef MULDIV_DIV_EN
               else begin
                  a_sh <= div_nxt;
               end
`endif
            end
            FIN: if (wr_en) begin
               d_hold  <= result;
               da_hold <= dst_q;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      result = d_hold;
      case (op_q)
         2'b00: result = prod[WIDTH-1:0];
         2'b01: result = prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
         2'b10: result = divz_q ? {WIDTH{1'b1}} : a_sh[WIDTH-1:0];
         2'b11: result = divz_q ? a_sh[WIDTH-1:0] : a_sh[2*WIDTH-1:WIDTH];
`endif
         default: ;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == FIN);
      wr   = done && wr_en;
`ifdef MULDIV_DIV_EN
      divz = done && divz_q;
`else
      divz = 1'b0;
`endif
      d    = wr ? result : d_hold;
      da   = wr ? dst_q  : da_hold;
   end
endmodule
